// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR types and helpers
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        COUNT   = 2'd2,
        DONE    = 2'd3
    } mon_state_t;

    function automatic logic [31:0] max_period(input int width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/lfsr_period_monitor.sv
// rtl/lfsr_period_monitor.sv - measures the period of an upstream LFSR stream
module lfsr_period_monitor
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = WIDTH + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             valid,
    input  logic [WIDTH-1:0] lfsr_q,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] period,
    output logic             maximal,
    output logic             stuck_zero,
    output logic             no_repeat
);

    localparam logic [CNT_W-1:0] MAXP  = CNT_W'(max_period(WIDTH));
    localparam logic [CNT_W-1:0] LIMIT = MAXP + 1'b1;

    mon_state_t       state_q, state_d;
    logic [WIDTH-1:0] ref_q, ref_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             maximal_q, maximal_d;
    logic             stuck_q, stuck_d;
    logic             norep_q, norep_d;
    logic [CNT_W-1:0] cnt_next;

    assign cnt_next = cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        ref_d     = ref_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        maximal_d = maximal_q;
        stuck_d   = stuck_q;
        norep_d   = norep_q;
        case (state_q)
            IDLE, DONE: begin
                // A fresh start wipes the previous result on the same edge it arms.
                if (start) begin
                    state_d   = CAPTURE;
                    period_d  = '0;
                    maximal_d = 1'b0;
                    stuck_d   = 1'b0;
                    norep_d   = 1'b0;
                end
            end
            CAPTURE: begin
                if (valid) begin
                    ref_d = lfsr_q;
                    cnt_d = '0;
                    if (lfsr_q == '0) begin
                        stuck_d  = 1'b1;
                        period_d = '0;
                        state_d  = DONE;
                    end else begin
                        state_d = COUNT;
                    end
                end
            end
            COUNT: begin
                // Zero beats a match, a match beats the advance limit.
                if (valid) begin
                    if (lfsr_q == '0) begin
                        stuck_d  = 1'b1;
                        period_d = '0;
                        state_d  = DONE;
                    end else if (lfsr_q == ref_q) begin
                        period_d  = cnt_next;
                        maximal_d = (cnt_next == MAXP);
                        state_d   = DONE;
                    end else if (cnt_next == LIMIT) begin
                        norep_d  = 1'b1;
                        period_d = '0;
                        state_d  = DONE;
                    end else begin
                        cnt_d = cnt_next;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            ref_q     <= '0;
            cnt_q     <= '0;
            period_q  <= '0;
            maximal_q <= 1'b0;
            stuck_q   <= 1'b0;
            norep_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ref_q     <= ref_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            maximal_q <= maximal_d;
            stuck_q   <= stuck_d;
            norep_q   <= norep_d;
        end
    end

    assign busy       = (state_q == CAPTURE) || (state_q == COUNT);
    assign done       = (state_q == DONE);
    assign period     = period_q;
    assign maximal    = maximal_q;
    assign stuck_zero = stuck_q;
    assign no_repeat  = norep_q;

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// tb/tb_lfsr_period_monitor.sv - self-checking bench for lfsr_period_monitor
module tb_lfsr_period_monitor;

    localparam int W = 4;
    localparam int C = W + 1;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         valid = 1'b0;
    logic [W-1:0] lfsr_q = '0;
    logic         busy, done, maximal, stuck_zero, no_repeat;
    logic [C-1:0] period;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    lfsr_period_monitor #(.WIDTH(W), .CNT_W(C)) dut (
        .clk(clk), .reset(reset), .start(start), .valid(valid), .lfsr_q(lfsr_q),
        .busy(busy), .done(done), .period(period), .maximal(maximal),
        .stuck_zero(stuck_zero), .no_repeat(no_repeat)
    );

    always #5 clk = ~clk;

    // Reference model: 0 idle, 1 measuring, 2 result ready
    int           m_mode = 0;
    int           m_period = 0;
    bit           m_max = 0, m_zero = 0, m_norep = 0;
    logic [W-1:0] samp[$];

    function automatic void evaluate();
        int last = samp.size() - 1;
        if (samp[0] == '0) begin
            m_zero = 1; m_period = 0; m_mode = 2;
        end else if (last >= 1) begin
            if (samp[last] == '0) begin
                m_zero = 1; m_period = 0; m_mode = 2;
            end else if (samp[last] == samp[0]) begin
                m_period = last; m_max = (last == (1 << W) - 1); m_mode = 2;
            end else if (last == (1 << W)) begin
                m_norep = 1; m_period = 0; m_mode = 2;
            end
        end
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_mode = 0; m_period = 0; m_max = 0; m_zero = 0; m_norep = 0;
            samp.delete();
        end else if (m_mode != 1) begin
            if (start) begin
                m_mode = 1; m_period = 0; m_max = 0; m_zero = 0; m_norep = 0;
                samp.delete();
            end
        end else if (valid) begin
            samp.push_back(lfsr_q);
            evaluate();
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_mode == 1));
            chk("done", 32'(done), 32'(m_mode == 2));
            chk("period", 32'(period), 32'(m_period));
            chk("maximal", 32'(maximal), 32'(m_max));
            chk("stuck_zero", 32'(stuck_zero), 32'(m_zero));
            chk("no_repeat", 32'(no_repeat), 32'(m_norep));
        end
    end

    logic [W-1:0] stim[$];

    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] v);
        return {v[W-2:0], v[3] ^ v[0]};
    endfunction

    task automatic load_lfsr(input logic [W-1:0] seed, input int n);
        logic [W-1:0] v = seed;
        stim.delete();
        for (int i = 0; i < n; i++) begin
            stim.push_back(v);
            v = lfsr_step(v);
        end
    endtask

    // Pulse start, then feed stim on every gap-th cycle until the model reports a result.
    task automatic run(input int gap, input bit mid_start, input int stop_after);
        int idx = 0;
        int cyc = 0;
        @(posedge clk); #1;
        start = 1'b1; valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        while (m_mode != 2 && idx < stop_after) begin
            if (cyc >= 400 || idx >= stim.size()) begin
                chk("run_bound", 32'(cyc), 32'(400));
                break;
            end
            start = mid_start && (idx == 5);
            if (cyc % gap == gap - 1) begin
                valid = 1'b1; lfsr_q = stim[idx]; idx++;
            end else begin
                valid = 1'b0; lfsr_q = '0;
            end
            cyc++;
            @(posedge clk); #1;
        end
        valid = 1'b0; start = 1'b0; lfsr_q = '0;
    endtask

    initial begin
        reset = 1'b0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b1;

        // Start and valid in the same IDLE cycle: the valid must not be captured.
        start = 1'b1; valid = 1'b1; lfsr_q = 4'd0;
        @(posedge clk); #1;
        start = 1'b0; valid = 1'b0;
        chk("idle_start_busy", 32'(busy), 32'd1);
        chk("idle_start_zero", 32'(stuck_zero), 32'd0);

        load_lfsr(4'b0001, 20);
        run(1, 1'b0, 1000);
        chk("t1_period", 32'(period), 32'd15);
        chk("t1_maximal", 32'(maximal), 32'd1);

        stim = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd1, 4'd2};
        run(1, 1'b0, 1000);
        chk("t2_period", 32'(period), 32'd6);
        chk("t2_maximal", 32'(maximal), 32'd0);

        stim = '{4'd0, 4'd5};
        run(1, 1'b0, 1000);
        chk("t3_stuck", 32'(stuck_zero), 32'd1);
        chk("t3_period", 32'(period), 32'd0);

        stim = '{4'd1, 4'd2, 4'd3};
        for (int i = 0; i < 20; i++) stim.push_back(4'(4 + (i % 5)));
        run(1, 1'b0, 1000);
        chk("t4_norep", 32'(no_repeat), 32'd1);
        chk("t4_period", 32'(period), 32'd0);

        load_lfsr(4'b0001, 20);
        run(3, 1'b1, 1000);
        chk("t5_period", 32'(period), 32'd15);
        chk("t5_maximal", 32'(maximal), 32'd1);

        run(1, 1'b0, 6);
        valid = 1'b1; lfsr_q = 4'd5;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1; valid = 1'b0;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_period", 32'(period), 32'd0);
        run(1, 1'b0, 1000);
        chk("t6_rerun_period", 32'(period), 32'd15);

        @(posedge clk); #1;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
